// File: rtl/system_bd_gpio_in_cond.sv
// -----------------------------------------------------------------------------
// system_bd_gpio_in_cond
//   Input conditioning in front of the system GPIO PIO. Each raw board input is
//   synchronised, optionally debounced, and qualified rising/falling edges are
//   latched into sticky capture bits that feed the PIO in_port, so the PIO's
//   level IRQ fires on latched events.
//
//   Build option: define GPIO_IN_DEBOUNCE_EN to include the per-bit debounce
//   counters. When it is undefined, the debounced level simply follows the
//   synchroniser output every cycle, and DEBOUNCE_CYCLES/CNT_W are unused.
//
//   Ports:
//     clk, reset_n      clock, asynchronous active-low reset
//     gpio_raw          asynchronous board inputs
//     address, chipselect, write_n, writedata
//                       Avalon-MM slave: 0 level (RO), 1 capture (W1C),
//                       2 rise_en (RW), 3 fall_en (RW)
//     readdata          registered read data, 1-cycle latency
//     cond_out          sticky edge-capture bits (to PIO in_port)
//     level_out         debounced level
// -----------------------------------------------------------------------------
module system_bd_gpio_in_cond #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] gpio_raw,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] cond_out,
  output logic [WIDTH-1:0] level_out
);

  // Reject impossible configurations at elaboration.
  if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 2 ||
      (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cfg
    $error("system_bd_gpio_in_cond: invalid WIDTH/DEBOUNCE_CYCLES/CNT_W");
  end

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;

  logic [WIDTH-1:0] w_stable_next;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_cap_next;
  logic             w_wr;
  logic [31:0]      w_rd;

  // Two-flop synchroniser, nothing between the stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= gpio_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0][CNT_W-1:0] w_cnt_next;

  // A bit's level is accepted only after it has disagreed with the stable
  // value for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
  always_comb begin
    w_stable_next = r_stable;
    w_cnt_next    = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (r_sync2[i] != r_stable[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_stable_next[i] = r_sync2[i];
        end else begin
          w_cnt_next[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end
`else
  always_comb begin
    w_stable_next = r_sync2;
  end
`endif

  // Edges are judged on the same clock that moves the stable level.
  assign w_rise = w_stable_next & ~r_stable;
  assign w_fall = ~w_stable_next & r_stable;
  assign w_wr   = chipselect & ~write_n;
  assign w_clr  = (w_wr && address == 2'd1) ? writedata[WIDTH-1:0] : '0;

  // The set terms are OR-ed after the clear, so a new edge beats a
  // simultaneous W1C of the same bit.
  assign w_cap_next = (r_cap & ~w_clr) | (w_rise & r_rise_en) | (w_fall & r_fall_en);

  always_comb begin
    w_rd = '0;
    unique case (address)
      2'd0:    w_rd[WIDTH-1:0] = r_stable;
      2'd1:    w_rd[WIDTH-1:0] = r_cap;
      2'd2:    w_rd[WIDTH-1:0] = r_rise_en;
      default: w_rd[WIDTH-1:0] = r_fall_en;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable  <= '0;
      r_cap     <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      readdata  <= '0;
    end else begin
      r_stable <= w_stable_next;
      r_cap    <= w_cap_next;
      readdata <= w_rd;
      if (w_wr && address == 2'd2) r_rise_en <= writedata[WIDTH-1:0];
      if (w_wr && address == 2'd3) r_fall_en <= writedata[WIDTH-1:0];
    end
  end

  assign cond_out  = r_cap;
  assign level_out = r_stable;

endmodule

// File: tb/tb_system_bd_gpio_in_cond.sv
// -----------------------------------------------------------------------------
// tb_system_bd_gpio_in_cond
//   Self-checking bench for system_bd_gpio_in_cond (WIDTH=32,
//   DEBOUNCE_CYCLES=4, CNT_W=3). Works for either setting of
//   GPIO_IN_DEBOUNCE_EN.
// -----------------------------------------------------------------------------
module tb_system_bd_gpio_in_cond;

  localparam int unsigned DB = 4;
`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int WIN = DB;   // consecutive disagreeing samples needed
`else
  localparam int WIN = 1;
`endif
  // Raw value present before edge 0 shows on level_out after edge LAT.
  localparam int LAT = WIN + 1;

  logic        clk;
  logic        reset_n;
  logic [31:0] gpio_raw;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] cond_out;
  logic [31:0] level_out;

  system_bd_gpio_in_cond #(
    .WIDTH(32),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .gpio_raw(gpio_raw),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .cond_out(cond_out),
    .level_out(level_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit auto_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // History of raw samples, newest first. A bit's level flips once the
  // synchronised samples (two clocks old) have disagreed with it for WIN
  // consecutive clocks.
  logic [31:0] m_q[$];
  logic [31:0] m_stable, m_cap, m_rise, m_fall, m_rd;

  initial begin
    m_stable = '0; m_cap = '0; m_rise = '0; m_fall = '0; m_rd = '0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_q = {};
        for (int k = 0; k < WIN + 2; k++) m_q.push_front(32'h0);
        m_stable = '0; m_cap = '0; m_rise = '0; m_fall = '0; m_rd = '0;
      end else begin
        logic [31:0] acc, nxt, clr;
        bit          wr;
        acc = '1;
        for (int k = 1; k <= WIN; k++) acc &= (m_q[k] ^ m_stable);
        nxt = m_stable ^ acc;
        wr  = chipselect && !write_n;
        clr = (wr && address == 2'd1) ? writedata : 32'h0;
        case (address)
          2'd0:    m_rd = m_stable;
          2'd1:    m_rd = m_cap;
          2'd2:    m_rd = m_rise;
          default: m_rd = m_fall;
        endcase
        m_cap = (m_cap & ~clr) | (nxt & ~m_stable & m_rise) | (~nxt & m_stable & m_fall);
        m_stable = nxt;
        if (wr && address == 2'd2) m_rise = writedata;
        if (wr && address == 2'd3) m_fall = writedata;
        m_q.push_front(gpio_raw);
        void'(m_q.pop_back());
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (auto_en) begin
        check("model_level", level_out, m_stable);
        check("model_cond",  cond_out,  m_cap);
        check("model_rd",    readdata,  m_rd);
      end
    end
  end

  // ---------------- bus helpers (enter and leave on a negedge) ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic measure(input int b, output int n);
    n = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (level_out[b]) begin
        n = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [1:0]  addr;
    bit          wr;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int n;
    tbl[0]  = '{2'd0, 1'b0, 32'h0,        1'b1, 32'h0};
    tbl[1]  = '{2'd1, 1'b0, 32'h0,        1'b1, 32'h0};
    tbl[2]  = '{2'd2, 1'b0, 32'h0,        1'b1, 32'h0};
    tbl[3]  = '{2'd3, 1'b0, 32'h0,        1'b1, 32'h0};
    tbl[4]  = '{2'd2, 1'b1, 32'hA5A50F0F, 1'b0, 32'h0};
    tbl[5]  = '{2'd3, 1'b1, 32'h12348001, 1'b0, 32'h0};
    tbl[6]  = '{2'd2, 1'b0, 32'h0,        1'b1, 32'hA5A50F0F};
    tbl[7]  = '{2'd3, 1'b0, 32'h0,        1'b1, 32'h12348001};
    tbl[8]  = '{2'd0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0};
    tbl[9]  = '{2'd0, 1'b0, 32'h0,        1'b1, 32'h0};
    tbl[10] = '{2'd1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0};
    tbl[11] = '{2'd1, 1'b0, 32'h0,        1'b1, 32'h0};
    tbl[12] = '{2'd2, 1'b1, 32'h0,        1'b0, 32'h0};
    tbl[13] = '{2'd3, 1'b1, 32'h0,        1'b0, 32'h0};
    tbl[14] = '{2'd2, 1'b0, 32'h0,        1'b1, 32'h0};

    reset_n = 1'b0; gpio_raw = '0; address = '0; chipselect = 1'b0;
    write_n = 1'b1; writedata = '0;
    repeat (3) @(negedge clk);
    check("rst_cond",  cond_out,  32'h0);
    check("rst_level", level_out, 32'h0);
    check("rst_rd",    readdata,  32'h0);
    reset_n = 1'b1;
    auto_en = 1'b1;

    // Register map vectors
    for (int i = 0; i < 15; i++) begin
      address = tbl[i].addr; writedata = tbl[i].wdata;
      chipselect = 1'b1; write_n = !tbl[i].wr;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      if (tbl[i].chk) check($sformatf("tbl%0d_rd", i), readdata, tbl[i].exp);
    end

    // Rise latency on bit 0
    bus_write(2'd2, 32'h1);
    gpio_raw[0] = 1'b1;
    measure(0, n);
    check("lat_bit0", n, LAT);
    check("lat_cond", cond_out, 32'h1);
    address = 2'd1;
    @(negedge clk);
    check("lat_rd1", readdata, 32'h1);

    // Short pulse on bit 3
    bus_write(2'd2, 32'h9);
`ifdef GPIO_IN_DEBOUNCE_EN
    gpio_raw[3] = 1'b1; repeat (3) @(negedge clk); gpio_raw[3] = 1'b0;
    repeat (12) @(negedge clk);
    check("glitch3_level", level_out, 32'h1);
    check("glitch3_cond",  cond_out,  32'h1);
    gpio_raw[3] = 1'b1; repeat (4) @(negedge clk); gpio_raw[3] = 1'b0;
    repeat (2) @(negedge clk);
    check("pulse4_level", level_out, 32'h9);
    check("pulse4_cond",  cond_out,  32'h9);
    repeat (12) @(negedge clk);
    check("pulse4_fell", level_out, 32'h1);
`else
    gpio_raw[3] = 1'b1; @(negedge clk); gpio_raw[3] = 1'b0;
    @(negedge clk);
    check("pulse1_pre", level_out, 32'h1);
    @(negedge clk);
    check("pulse1_level", level_out, 32'h9);
    check("pulse1_cond",  cond_out,  32'h9);
    @(negedge clk);
    check("pulse1_fell", level_out, 32'h1);
`endif

    // Fall-only capture on bit 31
    bus_write(2'd1, 32'hFFFFFFFF);
    bus_write(2'd2, 32'h0);
    bus_write(2'd3, 32'h80000000);
    gpio_raw[31] = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    check("b31_hi_level", level_out, 32'h80000001);
    check("b31_hi_cond",  cond_out,  32'h0);
    gpio_raw[31] = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    check("b31_lo_level", level_out, 32'h1);
    check("b31_fall_cond", cond_out, 32'h80000000);
    bus_write(2'd1, 32'h80000000);
    check("b31_w1c", cond_out, 32'h0);

    // W1C on the same edge that sets bit 5
    bus_write(2'd2, 32'h20);
    gpio_raw[5] = 1'b1;
    repeat (LAT) @(negedge clk);
    bus_write(2'd1, 32'h20);
    check("race_level", level_out, 32'h21);
    check("race_cond",  cond_out,  32'h20);
    bus_write(2'd1, 32'h0);
    check("w1c_zero", cond_out, 32'h20);
    bus_write(2'd1, 32'h20);
    check("w1c_bit5", cond_out, 32'h0);

    // Reset in the middle of a debounce count on bit 1
    gpio_raw[1] = 1'b1;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mrst_level", level_out, 32'h0);
    check("mrst_cond",  cond_out,  32'h0);
    check("mrst_rd",    readdata,  32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    measure(1, n);
    check("mrst_lat", n, LAT);
    check("mrst_level_all", level_out, 32'h23);
    check("mrst_cond_after", cond_out, 32'h0);

    // Randomised traffic against the model
    bus_write(2'd2, $urandom);
    bus_write(2'd3, $urandom);
    for (int c = 0; c < 800; c++) begin
      gpio_raw = gpio_raw ^ ($urandom & $urandom & $urandom & $urandom);
      if ($urandom_range(0, 3) == 0) begin
        chipselect = 1'b0;
        write_n = $urandom_range(0, 1) == 1;
      end else begin
        chipselect = 1'b1;
        write_n = $urandom_range(0, 2) != 0;
      end
      address = 2'($urandom_range(0, 3));
      writedata = $urandom;
      @(negedge clk);
    end
    chipselect = 1'b0; write_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
